// File: rtl/lut_config_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : lut_cfg_stream_if
//  Description : Valid/ready beat stream carrying the LUT configuration
//                bitstream from the fabric config controller to the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lut_cfg_stream_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    // Producer side (config controller)
    modport master (output in_data, output in_valid, input in_ready);
    // Consumer side (loader)
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/lut_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : lut_config_loader
//  Description : Collects BEATS bitstream beats into one CFG_W-bit config word
//                and presents it to a LUT / LUT-pair with a 1-cycle cen strobe.
//                First beat lands in the config word MSBs.
//  Options     : LUT_CFG_READBACK_EN - adds a READBACK state that streams the
//                committed config word back out, MSB beat first.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_config_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2**INPUTS,
    parameter int CFG_W    = 2*MEM_SIZE,
    parameter int DATA_W   = 8
) (
    input  wire logic              cclk,
    input  wire logic              rst,
    input  wire logic              i_start,
    input  wire logic              i_abort,
    lut_cfg_stream_if.slave        s_in,
    output logic [CFG_W-1:0]       o_config_out,
    output logic                   o_cen,
    output logic                   o_busy,
    output logic                   o_done
`ifdef LUT_CFG_READBACK_EN
    ,
    input  wire logic              i_rb_req,
    output logic [DATA_W-1:0]      o_rb_data,
    output logic                   o_rb_valid,
    input  wire logic              i_rb_ready
`endif
);

    localparam int BEATS = CFG_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_COMMIT   = 2'd2
`ifdef LUT_CFG_READBACK_EN
        ,
        S_READBACK = 2'd3
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic [CFG_W-1:0]   r_shift;
    logic [CFG_W-1:0]   r_config;
    logic               r_done;
    logic               w_in_ready;
    logic               w_cen;
    logic               w_busy;
    logic               w_accept;
    logic               w_last;
    logic [CFG_W-1:0]   w_word;

    // Beat acceptance and the word as it would look after shifting this beat in
    assign w_accept = s_in.in_valid && (r_state == S_LOAD);
    assign w_last   = w_accept && (r_count == LAST_CNT);
    assign w_word   = (r_shift << DATA_W) | CFG_W'(s_in.in_data);

    // State register
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_cen      = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    w_next = S_LOAD;
                end
`ifdef LUT_CFG_READBACK_EN
                else if (i_rb_req) begin
                    w_next = S_READBACK;
                end
`endif
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                // abort outranks a coinciding last beat
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_cen  = 1'b1;
                w_next = S_IDLE;
            end
`ifdef LUT_CFG_READBACK_EN
            S_READBACK: begin
                if (i_rb_ready && (r_count == LAST_CNT)) begin
                    w_next = S_IDLE;
                end
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: beat counter, assembly shift register, committed word, done pulse
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_shift  <= '0;
            r_config <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_COMMIT);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_count <= '0;
                    end
`ifdef LUT_CFG_READBACK_EN
                    else if (i_rb_req) begin
                        // Readback reuses the shift register as its output queue
                        r_count <= '0;
                        r_shift <= r_config;
                    end
`endif
                end
                S_LOAD: begin
                    if (w_accept && !i_abort) begin
                        r_shift <= w_word;
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_config <= w_word;
                        end
                    end
                end
`ifdef LUT_CFG_READBACK_EN
                S_READBACK: begin
                    if (i_rb_ready) begin
                        r_shift <= r_shift << DATA_W;
                        r_count <= r_count + 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign s_in.in_ready = w_in_ready;
    assign o_config_out  = r_config;
    assign o_cen         = w_cen;
    assign o_busy        = w_busy;
    assign o_done        = r_done;

`ifdef LUT_CFG_READBACK_EN
    assign o_rb_valid = (r_state == S_READBACK);
    assign o_rb_data  = (r_state == S_READBACK) ? r_shift[CFG_W-1 -: DATA_W] : '0;
`endif

endmodule
`default_nettype wire
